cmd_dispatcher: RTL and testbench
=================================

CMD_DISPATCHER -- requirements
Module: cmd_dispatcher

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the divider register and the sample-count register.
REQ-002 SHALL have parameter ACK_BYTE, default 8'hA5: response byte for an accepted command.
REQ-003 SHALL have parameter NAK_BYTE, default 8'h5A: response byte for a rejected command.
REQ-004 SHALL have port clock  input  1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n  input  1: reset, synchronous and active-low.
REQ-006 SHALL have port cmd_recieved  input  1: command-complete strobe from the decoder; it may stay high for more than one cycle.
REQ-007 SHALL have port opcode  input  8: command opcode, valid while cmd_recieved is high.
REQ-008 SHALL have port command  input  32: command argument, valid while cmd_recieved is high.
REQ-009 SHALL have port trig_hit  input  1: trigger-unit match for the current sample.
REQ-010 SHALL have port sample_tick  output  1: one-cycle sample strobe.
REQ-011 SHALL have port trig_mask  output  32: trigger mask register.
REQ-012 SHALL have port trig_value  output  32: trigger value register.
REQ-013 SHALL have port capture_en  output  1: sampler write enable.
REQ-014 SHALL have port capture_done  output  1: capture-complete flag.
REQ-015 SHALL have port busy  output  1: high when the capture state is not IDLE.
REQ-016 SHALL have port rsp_valid  output  1: response byte valid.
REQ-017 SHALL have port rsp_byte  output  8: response byte.
REQ-018 SHALL have port rsp_ready  input  1: UART transmitter accepts the byte.

Function
REQ-019 SHALL treat a command as present only on the cycle cmd_recieved goes from 0 to 1 (rising edge), and SHALL execute each command exactly once.
REQ-020 SHALL decode opcodes as follows:
- 0x00 RESET_CAP
- 0x01 ARM
- 0x02 SET_DIV
- 0x03 SET_MASK
- 0x04 SET_VALUE
- 0x05 SET_COUNT
- 0x06 QUERY
- any other opcode SHALL be answered with NAK_BYTE and cause no state change.
REQ-021 SHALL apply SET_DIV/SET_MASK/SET_VALUE/SET_COUNT writes (command[CNT_W-1:0] or command) and answer ACK_BYTE only in IDLE or DONE; in ARMED or CAPTURE it SHALL answer NAK_BYTE and leave the register unchanged.
REQ-022 SHALL use capture states IDLE, ARMED, CAPTURE and DONE, with these transitions:
- ARM accepted in IDLE or DONE when sample_count != 0 -> ARMED; ARM with sample_count == 0 or in any other state -> NAK_BYTE.
- ARMED -> CAPTURE on a cycle where sample_tick and trig_hit are both high; that sample counts as the first sample.
- CAPTURE -> DONE on the sample_tick that completes sample_count samples.
- RESET_CAP in any state -> IDLE on the next cycle, answered with ACK_BYTE.
REQ-023 SHALL drive capture_en high exactly on the sample_tick cycles counted in CAPTURE, including the triggering tick.
REQ-024 SHALL hold capture_done high in DONE only.
REQ-025 SHALL have sample_tick pulse once every (divider+1) clocks, free-running in all states; divider = 0 SHALL give a tick on every clock.
REQ-026 SHALL restart the tick phase on a SET_DIV write.
REQ-027 SHALL assert rsp_valid with rsp_byte on the cycle after the command edge.
REQ-028 SHALL hold rsp_valid and rsp_byte stable until rsp_valid && rsp_ready; the byte is consumed on that cycle.
REQ-029 SHALL ignore a command edge arriving while a response is still unconsumed, and SHALL set a sticky ovf flag; RESET_CAP clears ovf.
REQ-030 SHALL finish DONE entry before processing a command that coincides with the final tick; RESET_CAP on that cycle wins.

Reset
REQ-031 SHALL, when reset_n is low at a clock edge, return to this state:
- state IDLE, divider 0, sample_count 0, ovf 0
- trig_mask 0, trig_value 0
- all outputs 0, including any response in progress
- edge detector primed so that a cmd_recieved already high after reset does not fire.

Configuration
REQ-032 SHALL, with STATUS_READBACK_EN defined, answer QUERY with 5 bytes: ACK_BYTE, then {state[1:0], ovf, 5'b0}, then the low 24 bits of the remaining sample count, MSB first, one byte per rsp handshake.
REQ-033 SHALL, without STATUS_READBACK_EN, answer QUERY with NAK_BYTE only.

Structure
REQ-034 SHALL take the opcode constants, the capture-state enum and the ACK/NAK defaults from shared package la_cmd_pkg.
REQ-035 SHALL implement the tick generator as sub-module sample_divider, with ports clock, reset_n, load, div, tick.

Verification
REQ-036 SHALL cover: SET_DIV 3, SET_COUNT 4, ARM, then trig_hit on the 2nd tick -> capture_en on 4 ticks spaced 4 clocks apart, then capture_done=1, with ACK 0xA5 each time.
REQ-037 SHALL cover: cmd_recieved held high 3 cycles with SET_MASK 0xFF -> exactly one write and one response byte.
REQ-038 SHALL cover: SET_MASK while ARMED -> NAK 0x5A and trig_mask unchanged.
REQ-039 SHALL cover: ARM with sample_count 0 -> NAK 0x5A and state stays IDLE.
REQ-040 SHALL cover: rsp_ready held low while a second command arrives -> second command dropped, and QUERY (STATUS_READBACK_EN) reports the ovf bit set.
REQ-041 SHALL cover: reset_n low during CAPTURE -> next cycle capture_en=0, busy=0, rsp_valid=0.

Source files
------------

// File: rtl/la_cmd_pkg.sv
// Shared opcodes, capture-state enum and response defaults
// for the logic-analyser command dispatcher.
package la_cmd_pkg;

  localparam logic [7:0] OP_RESET_CAP = 8'h00;
  localparam logic [7:0] OP_ARM       = 8'h01;
  localparam logic [7:0] OP_SET_DIV   = 8'h02;
  localparam logic [7:0] OP_SET_MASK  = 8'h03;
  localparam logic [7:0] OP_SET_VALUE = 8'h04;
  localparam logic [7:0] OP_SET_COUNT = 8'h05;
  localparam logic [7:0] OP_QUERY     = 8'h06;

  localparam logic [7:0] ACK_DEFAULT = 8'hA5;
  localparam logic [7:0] NAK_DEFAULT = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/cmd_dispatcher_sample_divider.sv
// Free-running sample strobe: one tick every div+1 clocks,
// phase restarted by load.
module sample_divider #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] div,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (load) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == div) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/cmd_dispatcher.sv
// Host command dispatcher and capture FSM for the logic analyser.
// Define STATUS_READBACK_EN to answer QUERY with a 5-byte status burst.
module cmd_dispatcher
  import la_cmd_pkg::*;
#(
  parameter int         CNT_W    = 32,
  parameter logic [7:0] ACK_BYTE = ACK_DEFAULT,
  parameter logic [7:0] NAK_BYTE = NAK_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_recieved,
  input  logic [7:0]  opcode,
  input  logic [31:0] command,
  input  logic        trig_hit,
  output logic        sample_tick,
  output logic [31:0] trig_mask,
  output logic [31:0] trig_value,
  output logic        capture_en,
  output logic        capture_done,
  output logic        busy,
  output logic        rsp_valid,
  output logic [7:0]  rsp_byte,
  input  logic        rsp_ready
);

  cap_state_t       state;
  cap_state_t       st_nx;
  logic [CNT_W-1:0] divider;
  logic [CNT_W-1:0] sample_count;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] rem_nx;

  logic cmd_q;
  logic cmd_edge;
  logic rsp_free;
  logic take;
  logic ovf;
  logic rd_more;
  logic load;
  logic ok;
  logic cfg_ok;

  logic is_rst, is_arm, is_div, is_msk;
  logic is_val, is_cnt, is_qry;

`ifdef STATUS_READBACK_EN
  localparam logic QRY_EN = 1'b1;
  logic [2:0]  rd_left;
  logic [31:0] rd_sr;
  logic [23:0] rem_lo;
  assign rd_more = (rd_left != 3'd0);
  assign rem_lo  = 24'(rem_nx);
`else
  localparam logic QRY_EN = 1'b0;
  assign rd_more = 1'b0;
`endif

  assign cmd_edge = cmd_recieved & ~cmd_q;
  assign rsp_free = ~rsp_valid | (rsp_ready & ~rd_more);
  assign take     = cmd_edge & rsp_free;
  assign load     = take & ok & is_div;

  assign busy         = (state != ST_IDLE);
  assign capture_done = (state == ST_DONE);

  sample_divider #(
    .CNT_W(CNT_W)
  ) u_div (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (load),
    .div    (divider),
    .tick   (sample_tick)
  );

  // Capture progress settles first; commands see the result.
  always_comb begin
    st_nx      = state;
    rem_nx     = remaining;
    capture_en = 1'b0;
    if (sample_tick &&
        ((state == ST_ARMED && trig_hit) ||
         state == ST_CAPTURE)) begin
      capture_en = 1'b1;
      rem_nx     = remaining - CNT_W'(1);
      st_nx      = (remaining == CNT_W'(1)) ?
                   ST_DONE : ST_CAPTURE;
    end
  end

  always_comb begin
    is_rst = (opcode == OP_RESET_CAP);
    is_arm = (opcode == OP_ARM);
    is_div = (opcode == OP_SET_DIV);
    is_msk = (opcode == OP_SET_MASK);
    is_val = (opcode == OP_SET_VALUE);
    is_cnt = (opcode == OP_SET_COUNT);
    is_qry = (opcode == OP_QUERY);
    cfg_ok = (st_nx == ST_IDLE) || (st_nx == ST_DONE);
    ok     = 1'b0;
    unique case (1'b1)
      is_rst: ok = 1'b1;
      is_arm: ok = cfg_ok && (sample_count != '0);
      is_div, is_msk, is_val, is_cnt: ok = cfg_ok;
      is_qry: ok = QRY_EN;
      default: ok = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      remaining    <= '0;
      divider      <= '0;
      sample_count <= '0;
      trig_mask    <= '0;
      trig_value   <= '0;
      ovf          <= 1'b0;
      cmd_q        <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_byte     <= '0;
`ifdef STATUS_READBACK_EN
      rd_left      <= '0;
      rd_sr        <= '0;
`endif
    end else begin
      cmd_q     <= cmd_recieved;
      state     <= st_nx;
      remaining <= rem_nx;
      if (cmd_edge && !rsp_free) begin
        ovf <= 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
`ifdef STATUS_READBACK_EN
        if (rd_more) begin
          rsp_byte <= rd_sr[31:24];
          rd_sr    <= {rd_sr[23:0], 8'h00};
          rd_left  <= rd_left - 3'd1;
        end else begin
          rsp_valid <= 1'b0;
        end
`else
        rsp_valid <= 1'b0;
`endif
      end
      if (take) begin
        rsp_valid <= 1'b1;
        rsp_byte  <= ok ? ACK_BYTE : NAK_BYTE;
        if (ok) begin
          unique case (1'b1)
            is_rst: begin
              state     <= ST_IDLE;
              remaining <= '0;
              ovf       <= 1'b0;
            end
            is_arm: begin
              state     <= ST_ARMED;
              remaining <= sample_count;
            end
            is_div: divider      <= CNT_W'(command);
            is_msk: trig_mask    <= command;
            is_val: trig_value   <= command;
            is_cnt: sample_count <= CNT_W'(command);
            is_qry: begin
`ifdef STATUS_READBACK_EN
              rd_left <= 3'd4;
              rd_sr   <= {st_nx, ovf, 5'b0, rem_lo};
`endif
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Randomised and directed bench for cmd_dispatcher against
// a queue-based behavioural model of the command protocol.
module tb_cmd_dispatcher;
  import la_cmd_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_recieved = 1'b1;
  logic [7:0]  opcode = 8'h01;
  logic [31:0] command = '0;
  logic        trig_hit = 1'b0;
  logic        rsp_ready = 1'b0;
  logic        sample_tick, capture_en, capture_done;
  logic        busy, rsp_valid;
  logic [31:0] trig_mask, trig_value;
  logic [7:0]  rsp_byte;

  always #5 clock = ~clock;

  cmd_dispatcher dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cmd_recieved(cmd_recieved),
    .opcode      (opcode),
    .command     (command),
    .trig_hit    (trig_hit),
    .sample_tick (sample_tick),
    .trig_mask   (trig_mask),
    .trig_value  (trig_value),
    .capture_en  (capture_en),
    .capture_done(capture_done),
    .busy        (busy),
    .rsp_valid   (rsp_valid),
    .rsp_byte    (rsp_byte),
    .rsp_ready   (rsp_ready)
  );

  localparam int M_IDLE = 0, M_ARMED = 1;
  localparam int M_CAP = 2, M_DONE = 3;

  int checks = 0;
  int errors = 0;

  int          m_st;
  longint      m_k;
  logic [31:0] m_div, m_cnt, m_rem, m_mask, m_val;
  bit          m_ovf, m_prev;
  logic [7:0]  m_q[$];

  longint     cyc = 0;
  longint     tick_cyc[$];
  longint     cap_cyc[$];
  logic [7:0] got[$];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               name, act, exp);
    end
  endtask

  function automatic logic [7:0] gb(input int i);
    return (i < got.size()) ? got[i] : 8'hEE;
  endfunction

  function automatic bit m_tick();
    return m_k > 0 && (m_k % (longint'(m_div) + 1)) == 0;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_k = 0; m_div = 0; m_cnt = 0;
    m_rem = 0; m_mask = 0; m_val = 0;
    m_ovf = 0; m_prev = 1; m_q.delete();
  endtask

  task automatic model_exec();
    bit ok, cfg;
    ok  = 0;
    cfg = (m_st == M_IDLE) || (m_st == M_DONE);
    case (opcode)
      8'h00: begin
        m_st = M_IDLE; m_rem = 0; m_ovf = 0; ok = 1;
      end
      8'h01: if (cfg && m_cnt != 0) begin
        m_st = M_ARMED; m_rem = m_cnt; ok = 1;
      end
      8'h02: if (cfg) begin m_div = command; m_k = 0; ok = 1; end
      8'h03: if (cfg) begin m_mask = command; ok = 1; end
      8'h04: if (cfg) begin m_val = command; ok = 1; end
      8'h05: if (cfg) begin m_cnt = command; ok = 1; end
`ifdef STATUS_READBACK_EN
      8'h06: ok = 1;
`endif
      default: ok = 0;
    endcase
    m_q.push_back(ok ? 8'hA5 : 8'h5A);
    if (ok && opcode == 8'h06) begin
      m_q.push_back(8'((m_st << 6) | (int'(m_ovf) << 5)));
      m_q.push_back(m_rem[23:16]);
      m_q.push_back(m_rem[15:8]);
      m_q.push_back(m_rem[7:0]);
    end
  endtask

  task automatic model_edge(input bit tk);
    bit edg, free;
    if (!reset_n) begin
      model_reset();
      return;
    end
    edg    = cmd_recieved && !m_prev;
    m_prev = cmd_recieved;
    free   = m_q.size() == 0 || (rsp_ready && m_q.size() == 1);
    if (m_q.size() > 0 && rsp_ready) void'(m_q.pop_front());
    if (tk && (m_st == M_CAP || (m_st == M_ARMED && trig_hit))) begin
      m_rem = m_rem - 1;
      m_st  = (m_rem == 0) ? M_DONE : M_CAP;
    end
    m_k++;
    if (edg) begin
      if (!free) m_ovf = 1;
      else model_exec();
    end
  endtask

  task automatic step();
    bit tk, ce;
    @(negedge clock);
    tk = m_tick();
    ce = tk && (m_st == M_CAP || (m_st == M_ARMED && trig_hit));
    chk("sample_tick", sample_tick, tk);
    chk("capture_en", capture_en, ce);
    chk("busy", busy, m_st != M_IDLE);
    chk("capture_done", capture_done, m_st == M_DONE);
    chk("trig_mask", trig_mask, m_mask);
    chk("trig_value", trig_value, m_val);
    chk("rsp_valid", rsp_valid, m_q.size() > 0);
    if (m_q.size() > 0) chk("rsp_byte", rsp_byte, m_q[0]);
    if (sample_tick) tick_cyc.push_back(cyc);
    if (capture_en) cap_cyc.push_back(cyc);
    if (rsp_valid && rsp_ready) got.push_back(rsp_byte);
    model_edge(tk);
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [7:0] op,
                      input logic [31:0] arg,
                      input int hold = 1);
    opcode = op; command = arg; cmd_recieved = 1'b1;
    repeat (hold) step();
    cmd_recieved = 1'b0;
    step();
    step();
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    model_reset();
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_byte", rsp_byte, 0);
    chk("rst_tick", sample_tick, 0);
    chk("rst_mask", trig_mask, 0);
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (4) step();
    chk("primed_no_rsp", got.size(), 0);
    cmd_recieved = 1'b0;
    step();

    got.delete();
    send(OP_SET_DIV, 3);
    send(OP_SET_COUNT, 4);
    send(OP_ARM, 0);
    chk("arm_acks", {gb(0), gb(1), gb(2)}, 24'hA5A5A5);
    tick_cyc.delete();
    cap_cyc.delete();
    for (int i = 0; i < 20 && tick_cyc.size() == 0; i++) step();
    trig_hit = 1'b1;
    for (int i = 0; i < 20 && cap_cyc.size() == 0; i++) step();
    trig_hit = 1'b0;
    repeat (20) step();
    chk("cap_count", cap_cyc.size(), 4);
    chk("cap_on_2nd_tick",
        cap_cyc.size() > 0 ? cap_cyc[0] - tick_cyc[0] : -1, 4);
    for (int i = 1; i < 4; i++)
      chk("cap_spacing",
          i < cap_cyc.size() ? cap_cyc[i] - cap_cyc[i-1] : -1, 4);
    chk("cap_done", capture_done, 1);

    got.delete();
    send(OP_SET_MASK, 32'hFF, 3);
    chk("hold3_one_rsp", got.size(), 1);
    chk("hold3_ack", gb(0), 8'hA5);
    chk("hold3_mask", trig_mask, 32'hFF);

    send(OP_RESET_CAP, 0);
    send(OP_SET_COUNT, 2);
    send(OP_SET_MASK, 32'h0F);
    send(OP_ARM, 0);
    got.delete();
    send(OP_SET_MASK, 32'hF0);
    chk("armed_mask_nak", gb(0), 8'h5A);
    chk("armed_mask_kept", trig_mask, 32'h0F);
    chk("armed_busy", busy, 1);

    send(OP_RESET_CAP, 0);
    send(OP_SET_COUNT, 0);
    got.delete();
    send(OP_ARM, 0);
    chk("arm0_nak", gb(0), 8'h5A);
    chk("arm0_idle", busy, 0);

    rsp_ready = 1'b0;
    send(OP_SET_VALUE, 1);
    send(OP_SET_VALUE, 2);
    rsp_ready = 1'b1;
    step();
    chk("ovf_first_kept", trig_value, 1);
    got.delete();
    send(OP_QUERY, 0);
    repeat (6) step();
`ifdef STATUS_READBACK_EN
    chk("query_len", got.size(), 5);
    chk("query_ack", gb(0), 8'hA5);
    chk("query_status", gb(1), 8'h20);
`else
    chk("query_len", got.size(), 1);
    chk("query_nak", gb(0), 8'h5A);
`endif
    send(OP_RESET_CAP, 0);

    send(OP_SET_DIV, 0);
    send(OP_SET_COUNT, 100);
    send(OP_ARM, 0);
    trig_hit = 1'b1;
    repeat (5) step();
    chk("mid_cap_en", capture_en, 1);
    chk("mid_cap_busy", busy, 1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("rst_cap_en", capture_en, 0);
    chk("rst_cap_busy", busy, 0);
    chk("rst_cap_rsp", rsp_valid, 0);
    trig_hit = 1'b0;
    step();

    for (int i = 0; i < 4000; i++) begin
      reset_n   = ($urandom_range(0, 599) != 0);
      trig_hit  = ($urandom_range(0, 2) == 0);
      rsp_ready = ($urandom_range(0, 9) < 7);
      if (!cmd_recieved) begin
        opcode = 8'($urandom_range(0, 8));
        case (opcode)
          8'h02:   command = $urandom_range(0, 4);
          8'h05:   command = $urandom_range(0, 6);
          default: command = $urandom;
        endcase
      end
      cmd_recieved = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
